// File: rtl/uart_rx_core_param_if.sv
// uart_rx_core_param_if: serial input, per-frame configuration and frame-result signals of uart_rx_core_param
interface uart_rx_core_param_if #(
  parameter int DATA_W = 8,
  parameter int PRESCALE_W = 6
);
  logic RX_IN, PAR_EN, PAR_TYP, STOP2;
  logic [PRESCALE_W-1:0] prescale;
  logic [DATA_W-1:0] data_out;
  logic data_valid, par_err, stp_err, strt_glitch, busy, break_det;
  modport master (
    output RX_IN, PAR_EN, PAR_TYP, STOP2, prescale,
    input data_out, data_valid, par_err, stp_err, strt_glitch, busy, break_det
  );
  modport slave (
    input RX_IN, PAR_EN, PAR_TYP, STOP2, prescale,
    output data_out, data_valid, par_err, stp_err, strt_glitch, busy, break_det
  );
endinterface

// File: rtl/uart_rx_core_param.sv
// uart_rx_core_param: oversampled UART receiver, 5..9 data bits, optional parity, 1 or 2 stop bits.
// Define UART_RX_BREAK_DET_EN to report all-zero frames as breaks and wait for line recovery.
module uart_rx_core_param #(
  parameter int DATA_W = 8,
  parameter int PRESCALE_W = 6
) (
  input logic CLK,
  input logic RST,
  uart_rx_core_param_if.slave rx_if
);
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2ST
`ifdef UART_RX_BREAK_DET_EN
    , BRK_WAIT
`endif
  } state_t;
  state_t state, state_n;
  logic [PRESCALE_W-1:0] edge_cnt, p_l, m;
  logic [3:0] bit_cnt;
  logic [DATA_W-1:0] shreg, data_out;
  logic par_en_l, par_typ_l, stop2_l, s0, s1, par_x, par_mis, stp_acc;
  logic data_valid, par_err, stp_err, strt_glitch;
  logic dv_n, pe_n, se_n, sg_n, rx, dec, dec_edge, last, done, stp_bad;
`ifdef UART_RX_BREAK_DET_EN
  logic zero_acc, break_det, bk_n;
  assign rx_if.break_det = break_det;
`else
  assign rx_if.break_det = 1'b0;
`endif
  assign rx = rx_if.RX_IN;
  assign m = p_l >> 1;
  assign last = edge_cnt == p_l - 1'b1;
  assign dec_edge = edge_cnt == m + 1'b1;
  assign dec = (s0 & s1) | (s0 & rx) | (s1 & rx);
  assign done = dec_edge && (state == STOP2ST || (state == STOP1 && !stop2_l));
  assign stp_bad = stp_acc | ~dec;
  assign rx_if.data_out = data_out;
  assign rx_if.data_valid = data_valid;
  assign rx_if.par_err = par_err;
  assign rx_if.stp_err = stp_err;
  assign rx_if.strt_glitch = strt_glitch;
  assign rx_if.busy = state != IDLE;
  always_comb begin
    state_n = state;
    dv_n = 1'b0;
    pe_n = 1'b0;
    se_n = 1'b0;
    sg_n = state == START && dec_edge && dec;
`ifdef UART_RX_BREAK_DET_EN
    bk_n = 1'b0;
`endif
    case (state)
      IDLE: state_n = rx ? IDLE : START;
      START: state_n = sg_n ? IDLE : last ? DATA : START;
      DATA: state_n = last && bit_cnt == 4'(DATA_W - 1) ? (par_en_l ? PARITY : STOP1) : DATA;
      PARITY: state_n = last ? STOP1 : PARITY;
      STOP1: state_n = last && stop2_l ? STOP2ST : STOP1;
`ifdef UART_RX_BREAK_DET_EN
      BRK_WAIT: state_n = dec && last ? IDLE : BRK_WAIT;
`endif
      default: state_n = state;
    endcase
    // returning to IDLE on the decision edge lets a start bit overlap the stop bit's tail
    if (done) begin
      state_n = IDLE;
      se_n = stp_bad;
      pe_n = par_mis;
      dv_n = !stp_bad && !par_mis;
`ifdef UART_RX_BREAK_DET_EN
      if (zero_acc && !dec) begin
        state_n = BRK_WAIT;
        bk_n = 1'b1;
        se_n = 1'b0;
        pe_n = 1'b0;
      end
`endif
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      edge_cnt <= '0;
      bit_cnt <= '0;
      p_l <= '0;
      par_en_l <= 1'b0;
      par_typ_l <= 1'b0;
      stop2_l <= 1'b0;
      s0 <= 1'b0;
      s1 <= 1'b0;
      shreg <= '0;
      par_x <= 1'b0;
      par_mis <= 1'b0;
      stp_acc <= 1'b0;
      data_out <= '0;
      data_valid <= 1'b0;
      par_err <= 1'b0;
      stp_err <= 1'b0;
      strt_glitch <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      zero_acc <= 1'b0;
      break_det <= 1'b0;
`endif
    end else begin
      state <= state_n;
      data_valid <= dv_n;
      par_err <= pe_n;
      stp_err <= se_n;
      strt_glitch <= sg_n;
      if (dv_n) data_out <= shreg;
`ifdef UART_RX_BREAK_DET_EN
      break_det <= bk_n;
`endif
      if (state == IDLE) begin
        // the edge that sees the start level is edge 0 of the start bit
        edge_cnt <= {{(PRESCALE_W-1){1'b0}}, ~rx};
        bit_cnt <= '0;
        p_l <= rx_if.prescale;
        par_en_l <= rx_if.PAR_EN;
        par_typ_l <= rx_if.PAR_TYP;
        stop2_l <= rx_if.STOP2;
        par_x <= 1'b0;
        par_mis <= 1'b0;
        stp_acc <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        zero_acc <= 1'b1;
      end else if (state == BRK_WAIT) begin
        s0 <= s1;
        s1 <= rx;
        edge_cnt <= dec ? edge_cnt + 1'b1 : '0;
      end else if (bk_n) begin
        edge_cnt <= '0;
`endif
      end else begin
        edge_cnt <= last ? '0 : edge_cnt + 1'b1;
        if (last && state == DATA) bit_cnt <= bit_cnt + 1'b1;
        if (edge_cnt == m - 1'b1) s0 <= rx;
        if (edge_cnt == m) s1 <= rx;
        if (dec_edge) begin
`ifdef UART_RX_BREAK_DET_EN
          zero_acc <= zero_acc & ~dec;
`endif
          if (state == DATA) shreg <= {dec, shreg[DATA_W-1:1]};
          if (state == DATA) par_x <= par_x ^ dec;
          if (state == PARITY) par_mis <= par_x ^ dec ^ par_typ_l;
          if (state == STOP1) stp_acc <= ~dec;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_core_param.sv
// tb_uart_rx_core_param: directed frames against uart_rx_core_param with hand-computed edges and data
module tb_uart_rx_core_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int pe_cnt = 0, se_cnt = 0, sg_cnt = 0, bk_cnt = 0;
  int pe_cyc = -1, se_cyc = -1, sg_cyc = -1, bk_cyc = -1;
  int long_cnt = 0, excl_cnt = 0;
  int dv_cyc_q[$];
  logic [7:0] dv_dat_q[$];
  logic [4:0] prev = 5'b0;
  uart_rx_core_param_if #(.DATA_W(8), .PRESCALE_W(6)) bus ();
  uart_rx_core_param #(.DATA_W(8), .PRESCALE_W(6)) dut (.CLK(clk), .RST(rst), .rx_if(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    logic [4:0] cur;
    cur = {bus.data_valid, bus.par_err, bus.stp_err, bus.strt_glitch, bus.break_det};
    if (cur[4]) begin
      dv_cyc_q.push_back(cyc);
      dv_dat_q.push_back(bus.data_out);
    end
    if (cur[3]) begin pe_cnt++; pe_cyc = cyc; end
    if (cur[2]) begin se_cnt++; se_cyc = cyc; end
    if (cur[1]) begin sg_cnt++; sg_cyc = cyc; end
    if (cur[0]) begin bk_cnt++; bk_cyc = cyc; end
    if (|(cur & prev)) long_cnt++;
    if (cur[4] && |cur[3:0]) excl_cnt++;
    prev = cur;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
  task automatic drive_bit(input logic b, input int p);
    bus.RX_IN = b;
    repeat (p) begin @(posedge clk); #1; end
  endtask
  task automatic send_bits(input logic [15:0] bits, input int n, input int p);
    for (int i = 0; i < n; i++) drive_bit(bits[i], p);
  endtask
  task automatic cfg(input int p, input logic pe, input logic pt, input logic s2);
    bus.prescale = 6'(p);
    bus.PAR_EN = pe;
    bus.PAR_TYP = pt;
    bus.STOP2 = s2;
  endtask
  task automatic test_reset;
    bus.RX_IN = 1'b1;
    cfg(16, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_chk++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out got %h exp 00", bus.data_out); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_chk++; if ({bus.data_valid, bus.par_err, bus.stp_err, bus.strt_glitch, bus.break_det} !== 5'b0) begin
      n_fail++; $display("FAIL reset_pulses got %b exp 00000", {bus.data_valid, bus.par_err, bus.stp_err, bus.strt_glitch, bus.break_det});
    end
    rst = 1'b0;
    drive_bit(1'b1, 4);
  endtask
  task automatic test_8n1;
    int t0, e0;
    cfg(16, 1'b0, 1'b0, 1'b0);
    dv_cyc_q.delete(); dv_dat_q.delete();
    e0 = pe_cnt + se_cnt + sg_cnt + bk_cnt;
    t0 = cyc + 1;
    send_bits(16'({1'b1, 8'hA5, 1'b0}), 10, 16);
    drive_bit(1'b1, 4);
    n_chk++; if (dv_cyc_q.size() !== 1) begin n_fail++; $display("FAIL 8n1_dv_count got %0d exp 1", dv_cyc_q.size()); end
    else begin
      n_chk++; if (dv_cyc_q[0] !== t0 + 153) begin n_fail++; $display("FAIL 8n1_latency got %0d exp %0d", dv_cyc_q[0], t0 + 153); end
    end
    n_chk++; if (bus.data_out !== 8'hA5) begin n_fail++; $display("FAIL 8n1_data got %h exp a5", bus.data_out); end
    n_chk++; if (pe_cnt + se_cnt + sg_cnt + bk_cnt !== e0) begin n_fail++; $display("FAIL 8n1_err_pulses got %0d exp %0d", pe_cnt + se_cnt + sg_cnt + bk_cnt, e0); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL 8n1_busy_after got %b exp 0", bus.busy); end
  endtask
  task automatic test_parity;
    int t0, p0, s0;
    cfg(8, 1'b1, 1'b0, 1'b0);
    dv_cyc_q.delete(); dv_dat_q.delete();
    p0 = pe_cnt; s0 = se_cnt;
    t0 = cyc + 1;
    send_bits(16'({1'b1, 1'b1, 8'h3C, 1'b0}), 11, 8);
    drive_bit(1'b1, 4);
    n_chk++; if (pe_cnt !== p0 + 1) begin n_fail++; $display("FAIL par_err_count got %0d exp %0d", pe_cnt, p0 + 1); end
    n_chk++; if (pe_cyc !== t0 + 85) begin n_fail++; $display("FAIL par_err_cycle got %0d exp %0d", pe_cyc, t0 + 85); end
    n_chk++; if (dv_cyc_q.size() !== 0) begin n_fail++; $display("FAIL par_no_dv got %0d exp 0", dv_cyc_q.size()); end
    n_chk++; if (se_cnt !== s0) begin n_fail++; $display("FAIL par_no_stp got %0d exp %0d", se_cnt, s0); end
    n_chk++; if (bus.data_out !== 8'hA5) begin n_fail++; $display("FAIL par_data_held got %h exp a5", bus.data_out); end
    cfg(8, 1'b1, 1'b1, 1'b0);
    t0 = cyc + 1;
    send_bits(16'({1'b1, 1'b1, 8'h3C, 1'b0}), 11, 8);
    drive_bit(1'b1, 4);
    n_chk++; if (dv_cyc_q.size() !== 1 || dv_cyc_q[0] !== t0 + 85) begin n_fail++; $display("FAIL odd_par_dv got n=%0d exp 1 at %0d", dv_cyc_q.size(), t0 + 85); end
    n_chk++; if (bus.data_out !== 8'h3C) begin n_fail++; $display("FAIL odd_par_data got %h exp 3c", bus.data_out); end
    n_chk++; if (pe_cnt !== p0 + 1) begin n_fail++; $display("FAIL odd_par_no_err got %0d exp %0d", pe_cnt, p0 + 1); end
  endtask
  task automatic test_stop2;
    int t0, s0;
    cfg(16, 1'b0, 1'b0, 1'b1);
    dv_cyc_q.delete(); dv_dat_q.delete();
    s0 = se_cnt;
    t0 = cyc + 1;
    send_bits(16'({2'b11, 8'h81, 1'b0}), 11, 16);
    drive_bit(1'b1, 4);
    n_chk++; if (dv_cyc_q.size() !== 1 || dv_cyc_q[0] !== t0 + 169) begin n_fail++; $display("FAIL stop2_good_dv got n=%0d exp 1 at %0d", dv_cyc_q.size(), t0 + 169); end
    n_chk++; if (bus.data_out !== 8'h81) begin n_fail++; $display("FAIL stop2_good_data got %h exp 81", bus.data_out); end
    dv_cyc_q.delete(); dv_dat_q.delete();
    t0 = cyc + 1;
    send_bits(16'({1'b0, 1'b1, 8'h81, 1'b0}), 11, 16);
    drive_bit(1'b1, 20);
    n_chk++; if (se_cnt !== s0 + 1) begin n_fail++; $display("FAIL stop2_err_count got %0d exp %0d", se_cnt, s0 + 1); end
    n_chk++; if (se_cyc !== t0 + 169) begin n_fail++; $display("FAIL stop2_err_cycle got %0d exp %0d", se_cyc, t0 + 169); end
    n_chk++; if (dv_cyc_q.size() !== 0) begin n_fail++; $display("FAIL stop2_err_no_dv got %0d exp 0", dv_cyc_q.size()); end
    n_chk++; if (bus.data_out !== 8'h81) begin n_fail++; $display("FAIL stop2_err_data_held got %h exp 81", bus.data_out); end
  endtask
  task automatic test_glitch;
    int t0, g0;
    cfg(16, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b1, 20);
    dv_cyc_q.delete(); dv_dat_q.delete();
    g0 = sg_cnt;
    t0 = cyc + 1;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 30);
    n_chk++; if (sg_cnt !== g0 + 1) begin n_fail++; $display("FAIL glitch_count got %0d exp %0d", sg_cnt, g0 + 1); end
    n_chk++; if (sg_cyc !== t0 + 9) begin n_fail++; $display("FAIL glitch_cycle got %0d exp %0d", sg_cyc, t0 + 9); end
    n_chk++; if (dv_cyc_q.size() !== 0) begin n_fail++; $display("FAIL glitch_no_dv got %0d exp 0", dv_cyc_q.size()); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle got busy=%b exp 0", bus.busy); end
  endtask
  task automatic test_back_to_back;
    int t0, e0;
    cfg(16, 1'b0, 1'b0, 1'b0);
    dv_cyc_q.delete(); dv_dat_q.delete();
    e0 = pe_cnt + se_cnt + sg_cnt + bk_cnt;
    t0 = cyc + 1;
    send_bits(16'({8'h55, 1'b0}), 9, 16);
    // stop bit high only through its decision edge; next start overlaps its tail
    drive_bit(1'b1, 9);
    send_bits(16'({1'b1, 8'hAA, 1'b0}), 10, 16);
    drive_bit(1'b1, 8);
    n_chk++; if (dv_cyc_q.size() !== 2) begin n_fail++; $display("FAIL b2b_dv_count got %0d exp 2", dv_cyc_q.size()); end
    else begin
      n_chk++; if (dv_cyc_q[0] !== t0 + 153 || dv_dat_q[0] !== 8'h55) begin n_fail++; $display("FAIL b2b_first got %h@%0d exp 55@%0d", dv_dat_q[0], dv_cyc_q[0], t0 + 153); end
      n_chk++; if (dv_cyc_q[1] !== t0 + 307 || dv_dat_q[1] !== 8'hAA) begin n_fail++; $display("FAIL b2b_second got %h@%0d exp aa@%0d", dv_dat_q[1], dv_cyc_q[1], t0 + 307); end
    end
    n_chk++; if (pe_cnt + se_cnt + sg_cnt + bk_cnt !== e0) begin n_fail++; $display("FAIL b2b_err_pulses got %0d exp %0d", pe_cnt + se_cnt + sg_cnt + bk_cnt, e0); end
  endtask
  task automatic test_reset_mid;
    int e0;
    cfg(16, 1'b0, 1'b0, 1'b0);
    dv_cyc_q.delete(); dv_dat_q.delete();
    e0 = pe_cnt + se_cnt + sg_cnt + bk_cnt;
    send_bits(16'({2'b11, 1'b0}), 3, 16);
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %b exp 1", bus.busy); end
    rst = 1'b1;
    drive_bit(1'b1, 2);
    rst = 1'b0;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
    drive_bit(1'b1, 200);
    n_chk++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_data got %h exp 00", bus.data_out); end
    n_chk++; if (dv_cyc_q.size() + pe_cnt + se_cnt + sg_cnt + bk_cnt !== e0) begin
      n_fail++; $display("FAIL midrst_no_pulses got %0d exp %0d", dv_cyc_q.size() + pe_cnt + se_cnt + sg_cnt + bk_cnt, e0);
    end
  endtask
  task automatic test_break;
    int t0, s0, b0;
    cfg(16, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b1, 4);
    dv_cyc_q.delete(); dv_dat_q.delete();
    s0 = se_cnt; b0 = bk_cnt;
    t0 = cyc + 1;
    drive_bit(1'b0, 200);
`ifdef UART_RX_BREAK_DET_EN
    n_chk++; if (bk_cnt !== b0 + 1 || bk_cyc !== t0 + 153) begin n_fail++; $display("FAIL break_pulse got n=%0d@%0d exp %0d@%0d", bk_cnt, bk_cyc, b0 + 1, t0 + 153); end
    n_chk++; if (se_cnt !== s0) begin n_fail++; $display("FAIL break_no_stp got %0d exp %0d", se_cnt, s0); end
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_low_line got %b exp 1", bus.busy); end
    drive_bit(1'b1, 13);
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_recovering got %b exp 1", bus.busy); end
    drive_bit(1'b1, 8);
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL break_idle got busy=%b exp 0", bus.busy); end
    n_chk++; if (dv_cyc_q.size() !== 0) begin n_fail++; $display("FAIL break_no_dv got %0d exp 0", dv_cyc_q.size()); end
`else
    n_chk++; if (se_cnt !== s0 + 1 || se_cyc !== t0 + 153) begin n_fail++; $display("FAIL zero_frame_stp got n=%0d@%0d exp %0d@%0d", se_cnt, se_cyc, s0 + 1, t0 + 153); end
    n_chk++; if (bk_cnt !== b0) begin n_fail++; $display("FAIL zero_frame_no_break got %0d exp %0d", bk_cnt, b0); end
    bus.RX_IN = 1'b1;
    for (int i = 0; i < 400 && dv_cyc_q.size() == 0; i++) begin @(posedge clk); #1; end
    n_chk++; if (dv_cyc_q.size() !== 1) begin n_fail++; $display("FAIL zero_frame_followup_dv got %0d exp 1", dv_cyc_q.size()); end
    else begin
      n_chk++; if (dv_cyc_q[0] !== t0 + 307 || dv_dat_q[0] !== 8'hFC) begin n_fail++; $display("FAIL zero_frame_followup got %h@%0d exp fc@%0d", dv_dat_q[0], dv_cyc_q[0], t0 + 307); end
    end
    drive_bit(1'b1, 20);
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_frame_idle got busy=%b exp 0", bus.busy); end
`endif
  endtask
  task automatic test_pulse_rules;
    n_chk++; if (long_cnt !== 0) begin n_fail++; $display("FAIL pulse_width got %0d long pulses exp 0", long_cnt); end
    n_chk++; if (excl_cnt !== 0) begin n_fail++; $display("FAIL pulse_exclusive got %0d overlaps exp 0", excl_cnt); end
  endtask
  initial begin
    test_reset;
    test_8n1;
    test_parity;
    test_stop2;
    test_glitch;
    test_back_to_back;
    test_reset_mid;
    test_break;
    test_pulse_rules;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
